// File: rtl/mpi_eth_stream_sink.sv
// Ethernet-style 64-bit stream sink: accepts beats, measures packet length,
// XOR-folds payload, counts packets/bytes and flags protocol errors.
// Optional macro MPI_ETH_STREAM_SINK_STALL_EN adds LFSR-driven backpressure.
module mpi_eth_stream_sink #(
  parameter int          MAX_PKT_BYTES = 9000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [63:0] stream_in_DATA,
  input  logic [7:0]  stream_in_KEEP,
  input  logic        stream_in_LAST,
  input  logic        stream_in_VALID,
  output logic        stream_in_READY,
  input  logic        clr_err,
  output logic        pkt_done,
  output logic [13:0] last_pkt_len,
  output logic [63:0] last_pkt_xor,
  output logic [31:0] pkt_count,
  output logic [31:0] byte_count,
  output logic [3:0]  err
);

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t      state, state_nxt;
  logic        accept, first;
  logic [3:0]  beat_bytes;
  logic [63:0] beat_data;
  logic [13:0] len_acc, len_new;
  logic [14:0] len_sum;
  logic [63:0] xor_acc, xor_new;
  logic        ovf_seen, over, keep_bad;
  logic        stall_q, last_q;
  logic [63:0] data_q;
  logic [7:0]  keep_q;
  logic [3:0]  err_new;

  assign accept = stream_in_VALID & stream_in_READY;
  assign first  = (state == IDLE);

  // Byte count of the beat and payload with unqualified bytes zeroed
  always_comb begin
    beat_bytes = 4'd0;
    beat_data  = 64'd0;
    for (int i = 0; i < 8; i++) begin
      beat_bytes = beat_bytes + 4'(stream_in_KEEP[i]);
      if (stream_in_KEEP[i]) beat_data[8*i +: 8] = stream_in_DATA[8*i +: 8];
    end
  end

  // Running length saturates at 14-bit max; the 15th bit catches the carry
  assign len_sum  = (first ? 15'd0 : {1'b0, len_acc}) + 15'(beat_bytes);
  assign len_new  = len_sum[14] ? 14'h3FFF : len_sum[13:0];
  assign xor_new  = first ? beat_data : (xor_acc ^ beat_data);
  assign over     = {18'd0, len_new} > 32'(MAX_PKT_BYTES);
  // Valid KEEP is a non-empty run of ones starting at bit 0
  assign keep_bad = (stream_in_KEEP == 8'd0) ||
                    ((stream_in_KEEP & (stream_in_KEEP + 8'd1)) != 8'd0);

  // New error events this cycle
  always_comb begin
    err_new    = 4'd0;
    err_new[0] = accept & keep_bad;
    err_new[1] = accept & ~stream_in_LAST & (stream_in_KEEP != 8'hFF);
    err_new[2] = stall_q & (~stream_in_VALID || stream_in_DATA != data_q ||
                            stream_in_KEEP != keep_q || stream_in_LAST != last_q);
    err_new[3] = accept & over & (first | ~ovf_seen);
  end

  // Packet framing next-state
  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = stream_in_LAST ? IDLE : IN_PKT;
  end

  // State register; reset drops any partial packet
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Packet accumulators, completion results and counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      len_acc      <= '0;
      xor_acc      <= '0;
      ovf_seen     <= 1'b0;
      pkt_done     <= 1'b0;
      last_pkt_len <= '0;
      last_pkt_xor <= '0;
      pkt_count    <= '0;
      byte_count   <= '0;
    end else begin
      pkt_done <= 1'b0;
      if (accept) begin
        len_acc    <= len_new;
        xor_acc    <= xor_new;
        ovf_seen   <= first ? over : (ovf_seen | over);
        byte_count <= byte_count + 32'(beat_bytes);
        if (stream_in_LAST) begin
          pkt_done     <= 1'b1;
          last_pkt_len <= len_new;
          last_pkt_xor <= xor_new;
          pkt_count    <= pkt_count + 32'd1;
        end
      end
    end
  end

  // Remember a stalled beat so the next cycle can check it was held
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      stall_q <= stream_in_VALID & ~stream_in_READY;
      data_q  <= stream_in_DATA;
      keep_q  <= stream_in_KEEP;
      last_q  <= stream_in_LAST;
    end
  end

  // Sticky errors; a new event wins over a simultaneous clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) err <= '0;
    else         err <= (clr_err ? 4'd0 : err) | err_new;
  end

`ifdef MPI_ETH_STREAM_SINK_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR (taps 16,14,13,11) throttles READY about 1 cycle in 4
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr            <= LFSR_SEED;
      stream_in_READY <= 1'b0;
    end else begin
      lfsr            <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      stream_in_READY <= (lfsr[1:0] != 2'b00);
    end
  end
`else
  // Always ready once the first post-reset edge has passed
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) stream_in_READY <= 1'b0;
    else         stream_in_READY <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mpi_eth_stream_sink.sv
// Randomized self-checking bench for mpi_eth_stream_sink with a packet-level model.
module tb_mpi_eth_stream_sink;
  localparam int MAXB = 9000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [63:0] data = '0;
  logic [7:0]  keep = '0;
  logic        last = 1'b0, valid = 1'b0, clr_err = 1'b0;
  logic        ready, pkt_done;
  logic [13:0] last_pkt_len;
  logic [63:0] last_pkt_xor;
  logic [31:0] pkt_count, byte_count;
  logic [3:0]  err;

  mpi_eth_stream_sink #(.MAX_PKT_BYTES(MAXB), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .resetn(resetn),
    .stream_in_DATA(data), .stream_in_KEEP(keep), .stream_in_LAST(last),
    .stream_in_VALID(valid), .stream_in_READY(ready), .clr_err(clr_err),
    .pkt_done(pkt_done), .last_pkt_len(last_pkt_len), .last_pkt_xor(last_pkt_xor),
    .pkt_count(pkt_count), .byte_count(byte_count), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // model state
  int unsigned m_bytes, m_pkts;
  logic [3:0]  m_err;
  int          pl, pbeats;
  logic [63:0] px;
  bit          povf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bytes = 0; m_pkts = 0; m_err = 0; pbeats = 0; pl = 0; px = 0; povf = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_done"}, pkt_done, 0);
    chk({tag, "_len"}, last_pkt_len, 0);
    chk({tag, "_xor"}, last_pkt_xor, 0);
    chk({tag, "_pkts"}, pkt_count, 0);
    chk({tag, "_bytes"}, byte_count, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 1'b0; valid = 0; clr_err = 0;
    #1;
    check_zero("rst");
    model_reset();
    @(negedge clk); resetn = 1'b1;
    #1 chk("rdy_after_release", ready, 0);
    @(posedge clk); #1;
    chk("rdy_first_edge", ready, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      chk("idle_done", pkt_done, 0);
    end
  endtask

  task automatic clear();
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    m_err = 0;
    chk("clr_err", err, m_err);
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l, input logic c);
    int n, cnt;
    data = d; keep = k; last = l; valid = 1'b1; clr_err = c;
    n = 0;
    forever begin
      @(negedge clk);
      if (ready) break;
      n++;
      if (n > 200) begin
        chk("ready_timeout", 0, 1);
        valid = 0; clr_err = 0;
        return;
      end
    end
    @(posedge clk); #1;
    valid = 1'b0; clr_err = 1'b0;
    // model: packet-level bookkeeping
    cnt = $countones(k);
    m_bytes += cnt;
    if (c) m_err = 0;
    if (cnt == 0 || k != 8'(8'hFF >> (8 - cnt))) m_err[0] = 1'b1;
    if (!l && k != 8'hFF) m_err[1] = 1'b1;
    if (pbeats == 0) begin pl = 0; px = 0; povf = 0; end
    pl += cnt;
    for (int b = 0; b < 8; b++) if (k[b]) px[8*b +: 8] ^= d[8*b +: 8];
    pbeats++;
    if (pl > MAXB && !povf) begin m_err[3] = 1'b1; povf = 1; end
    chk("pkt_done", pkt_done, l);
    chk("byte_count", byte_count, m_bytes);
    chk("err", err, m_err);
    if (l) begin
      m_pkts++;
      chk("last_len", last_pkt_len, (pl > 16383) ? 16383 : pl);
      chk("last_xor", last_pkt_xor, px);
      chk("pkt_count", pkt_count, m_pkts);
      pbeats = 0;
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int nb;
    logic [7:0] k;
    model_reset();
    do_reset();

    // single short beat
    send(64'h0102030405060708, 8'h0F, 1'b1, 1'b0);
    chk("single_xor_const", last_pkt_xor, 64'h05060708);
    chk("single_len_const", last_pkt_len, 4);

    // 3-beat packet, 19 bytes
    send(rnd64(), 8'hFF, 1'b0, 1'b0);
    send(rnd64(), 8'hFF, 1'b0, 1'b0);
    send(rnd64(), 8'h07, 1'b1, 1'b0);
    chk("three_len_const", last_pkt_len, 19);
    idle(1);

    // short non-last beat, clear, clear coinciding with bad KEEP
    send(rnd64(), 8'h0F, 1'b0, 1'b0);
    chk("short_nonlast_err", err, 4'b0010);
    clear();
    send(rnd64(), 8'h05, 1'b1, 1'b1);
    chk("clr_with_new_err", err, 4'b0001);
    clear();

    // oversize packet: 1200 full beats then a full last beat
    for (int i = 0; i < 1200; i++) send(rnd64(), 8'hFF, 1'b0, 1'b0);
    send(rnd64(), 8'hFF, 1'b1, 1'b0);
    chk("ovf_len_const", last_pkt_len, 9608);
    chk("ovf_err_bit", err[3], 1);
    clear();

`ifdef MPI_ETH_STREAM_SINK_STALL_EN
    // withdraw a beat that was stalled
    begin
      int n = 0;
      forever begin
        @(negedge clk);
        if (!ready) break;
        n++;
        if (n > 500) begin chk("stall_wait_timeout", 0, 1); break; end
      end
      data = rnd64(); keep = 8'hFF; last = 1'b1; valid = 1'b1;
      @(posedge clk); #1 valid = 1'b0;
      @(posedge clk); #1;
      m_err[2] = 1'b1;
      chk("withdraw_err2", err, m_err);
      clear();
    end
`endif

    // randomized packets
    for (int p = 0; p < 300; p++) begin
      nb = $urandom_range(1, 5);
      for (int b = 0; b < nb; b++) begin
        if (b == nb - 1) begin
          k = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(8'hFF >> $urandom_range(0, 7));
          send(rnd64(), k, 1'b1, ($urandom_range(0, 15) == 0));
        end else begin
          k = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF;
          send(rnd64(), k, 1'b0, 1'b0);
        end
      end
      if ($urandom_range(0, 9) == 0) clear();
      idle($urandom_range(0, 2));
    end

    // reset in the middle of a packet
    send(rnd64(), 8'hFF, 1'b0, 1'b0);
    send(rnd64(), 8'hFF, 1'b0, 1'b0);
    do_reset();
    send(rnd64(), 8'hFF, 1'b0, 1'b0);
    send(rnd64(), 8'h3F, 1'b1, 1'b0);
    chk("post_reset_pkts", pkt_count, 1);
    chk("post_reset_len", last_pkt_len, 14);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
